sd_demodulator: RTL and testbench
=================================

# sd_demodulator

Sigma-delta demodulator: the receive-side counterpart of the audio SD_MODULATOR. Takes a 1-bit sigma-delta bitstream from an external comparator/modulator on a MKR or PEX pin and recovers PCM samples with a second-order CIC decimator. Output is signed two's-complement `pBITS` samples with a one-cycle strobe, sized to feed the same 24-bit audio paths that drive SD_MODULATOR.

## Interface
- `pBITS`, 24, output sample width; must satisfy `pBITS >= 2*pDECIM_BITS+1`
- `pDECIM_BITS`, 9, log2 of decimation ratio R (R = 2^pDECIM_BITS = 512)

- `iCLK`  in  1  bitstream/system clock; one clock, all logic on its rising edge
- `iRESETn`  in  1  reset, asynchronous, active-low
- `iSD`  in  1  raw bitstream, asynchronous to iCLK
- `oDATA`  out  pBITS  demodulated sample, signed, held between strobes
- `oSTROBE`  out  1  one-cycle pulse, oDATA new this cycle

## Operation
- Let D = pDECIM_BITS, R = 2^D, W = 2D+2 (internal signed width).
- Input sync: 2-flop synchronizer on iSD, both flops reset to 0. Synchronized bit x maps to +1 (x=1) or -1 (x=0).
- Integrators: I1 += ±1; I2 += I1; both W bits, updated every cycle. Modular wrap-around is intentional and must not saturate.
- Decimation counter: D bits, reset 0, increments every cycle, wraps R-1 -> 0. A boundary edge is any edge where the counter reads R-1.
- Comb, at boundary edge: `rI2_D <= I2`; `rC1 <= I2 - rI2_D`; `rC1_D <= rC1`. All W-bit modular.
- Output, edge after boundary: `C2 = rC1 - rC1_D`, range [-R^2, +R^2]. Saturate to 2D+1 signed bits: +R^2 -> R^2-1, all other values pass. Left-align into pBITS: `oDATA = sat << (pBITS-2D-1)`, with low bits zero.
- Warm-up: a 2-bit counter, reset 0, counts boundaries up to 2. oSTROBE and the oDATA update are suppressed for the first two boundaries after reset. The first strobe follows the third boundary.
- DC gain R^2; full-scale bitstream maps to full-scale output.

## Timing
- Reset values: oDATA = 0, oSTROBE = 0. All integrators, comb registers, counters and sync flops are 0.
- Edges are counted from the first rising edge after iRESETn deasserts, numbered 1.
- The boundary occurs at edge kR (k ≥ 1). oSTROBE is high for exactly one cycle after edge kR+1, for k ≥ 3.
- Strobe period is exactly R cycles; no jitter, never back-to-back.
- Input-to-integrator latency: 2 cycles (synchronizer). Group delay about R cycles plus 3.
- Reset asserted mid-operation: all outputs go to reset values immediately (async). Warm-up restarts; no strobe until edge 3R+1 after release.
- oDATA is stable in all non-strobe cycles; it changes only together with a strobe.
- Simultaneous saturation and wrap: the saturation check uses the modular comb result. The integrators' own wrap must not affect C2.

## Test plan
- Constant iSD=1, defaults → first oSTROBE after edge 1537, then every 512 cycles. oDATA = 0x7FFFE0 (+2^18 clipped to 2^18-1, <<5).
- Constant iSD=0 → oDATA = 0x800000 (-2^18 <<5), no clipping, strobes as above.
- Pattern 1,0 repeating → oDATA = 0x000000 on every strobe from the third boundary onward.
- Pattern 1,1,1,0 repeating (mean +0.5) → oDATA = 0x400000 on each strobe after warm-up.
- Constant iSD=1 for more than 2^21 cycles (integrator wrap) → every strobe still shows 0x7FFFE0 and the period stays 512.
- iRESETn pulsed low at cycle 800 for 3 cycles → oDATA and oSTROBE read 0 immediately. No strobe until 1537 edges after release, then correct values.

Source files
------------

// File: rtl/sd_demodulator.sv
// Sigma-delta bitstream demodulator: 2-flop input sync, second-order CIC
// decimator (R = 2^pDECIM_BITS), saturated and left-aligned PCM output.
module sd_demodulator #(
  parameter int pBITS       = 24,
  parameter int pDECIM_BITS = 9
) (
  input  logic             iCLK,
  input  logic             iRESETn,
  input  logic             iSD,
  output logic [pBITS-1:0] oDATA,
  output logic             oSTROBE
);

  localparam int D  = pDECIM_BITS;
  localparam int W  = 2*D + 2;
  localparam int SW = 2*D + 1;
  localparam int SH = pBITS - SW;

  localparam logic signed [W-1:0] ONE    = W'(1);
  localparam logic signed [W-1:0] C2_MAX = W'((1 << (2*D)) - 1);
  localparam logic signed [W-1:0] C2_MIN = ~C2_MAX;

  // Comb output spans [-R^2, +R^2]; only +R^2 falls outside SW signed bits.
  function automatic logic signed [SW-1:0] sat_c2(input logic signed [W-1:0] v);
    if (v > C2_MAX)
      return C2_MAX[SW-1:0];
    else if (v < C2_MIN)
      return C2_MIN[SW-1:0];
    else
      return v[SW-1:0];
  endfunction

  function automatic logic [pBITS-1:0] align_out(input logic signed [SW-1:0] s);
    logic [pBITS-1:0] t;
    t = pBITS'(unsigned'(s));
    return t << SH;
  endfunction

  logic                 sync_p0, sync_p1;
  logic signed [W-1:0]  i1_p2, i2_p2;
  logic [D-1:0]         cnt;
  logic [1:0]           warm;
  logic signed [W-1:0]  i2_dly_p3, c1_p3, c1_dly_p3;
  logic                 vld_p3;
  logic                 boundary;
  logic signed [W-1:0]  step;
  logic signed [W-1:0]  c2_p4;

  assign boundary = &cnt;
  assign step     = sync_p1 ? ONE : -ONE;
  assign c2_p4    = c1_p3 - c1_dly_p3;

  // Stage 0/1: synchronizer for the asynchronous bitstream
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= iSD;
      sync_p1 <= sync_p0;
    end
  end

  // Stage 2: integrators, free-running modular arithmetic
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      i1_p2 <= '0;
      i2_p2 <= '0;
    end else begin
      i1_p2 <= i1_p2 + step;
      i2_p2 <= i2_p2 + i1_p2;
    end
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      cnt  <= '0;
      warm <= 2'd0;
    end else begin
      cnt <= cnt + 1'b1;
      if (boundary && warm != 2'd2)
        warm <= warm + 2'd1;
    end
  end

  // Stage 3: decimated comb section, updated once per boundary
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      i2_dly_p3 <= '0;
      c1_p3     <= '0;
      c1_dly_p3 <= '0;
      vld_p3    <= 1'b0;
    end else begin
      vld_p3 <= boundary && (warm == 2'd2);
      if (boundary) begin
        i2_dly_p3 <= i2_p2;
        c1_p3     <= i2_p2 - i2_dly_p3;
        c1_dly_p3 <= c1_p3;
      end
    end
  end

  // Stage 4: second comb difference, saturation and output register
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      oDATA   <= '0;
      oSTROBE <= 1'b0;
    end else begin
      oSTROBE <= vld_p3;
      if (vld_p3)
        oDATA <= align_out(sat_c2(c2_p4));
    end
  end

endmodule

// File: tb/tb_sd_demodulator.sv
// Scoreboarded bench for sd_demodulator: default instance under directed
// bitstream patterns plus a minimum-width instance that wraps quickly.
module tb_sd_demodulator;

  typedef struct {
    int          edge_no;
    logic [23:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        sd;
  logic        small_sd;
  logic [23:0] data;
  logic        strobe;
  logic [8:0]  s_data;
  logic        s_strobe;

  int   checks = 0;
  int   fails  = 0;
  int   edge_no;
  int   s_last;
  exp_t sb[$];
  logic [3:0] pat;
  int   plen;
  int   pidx;

  sd_demodulator #(.pBITS(24), .pDECIM_BITS(9)) dut (
    .iCLK(clk), .iRESETn(rst_n), .iSD(sd), .oDATA(data), .oSTROBE(strobe)
  );

  sd_demodulator #(.pBITS(9), .pDECIM_BITS(4)) dut_small (
    .iCLK(clk), .iRESETn(rst_n), .iSD(small_sd), .oDATA(s_data), .oSTROBE(s_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_no <= 0;
    else        edge_no <= edge_no + 1;
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && strobe) begin
      checks++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_strobe edge=%0d observed=%h expected no strobe", edge_no, data);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        assert (data === e.data) else begin
          fails++;
          $error("FAIL strobe_data edge=%0d observed=%h expected=%h", edge_no, data, e.data);
        end
        checks++;
        assert (edge_no === e.edge_no) else begin
          fails++;
          $error("FAIL strobe_edge observed=%0d expected=%0d", edge_no, e.edge_no);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) s_last = 0;
    else if (s_strobe) begin
      checks++;
      assert (s_data === 9'h0FF) else begin
        fails++;
        $error("FAIL small_wrap_data edge=%0d observed=%h expected=%h", edge_no, s_data, 9'h0FF);
      end
      checks++;
      assert ((s_last == 0) ? (edge_no == 49) : (edge_no - s_last == 16)) else begin
        fails++;
        $error("FAIL small_period edge=%0d observed_prev=%0d expected first=49 period=16", edge_no, s_last);
      end
      s_last = edge_no;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    sd   = pat[pidx];
    pidx = (pidx + 1) % plen;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    assert (data === 24'h0 && strobe === 1'b0) else begin
      fails++;
      $error("FAIL %s observed data=%h strobe=%b expected data=000000 strobe=0", tag, data, strobe);
    end
    checks++;
    assert (s_data === 9'h0 && s_strobe === 1'b0) else begin
      fails++;
      $error("FAIL %s_small observed data=%h strobe=%b expected 0/0", tag, s_data, s_strobe);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pidx  = 0;
  endtask

  task automatic expect_strobes(input logic [23:0] v, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.edge_no = 1537 + 512*k;
      e.data    = v;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    while (sb.size() > 0 && budget < 4000) begin
      step();
      budget++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL %s_timeout observed pending=%0d expected 0", tag, sb.size());
    end
    sb.delete();
    repeat (20) step();
  endtask

  initial begin
    int budget;
    rst_n    = 1'b0;
    sd       = 1'b0;
    small_sd = 1'b1;
    pat      = 4'b0001;
    plen     = 1;
    pidx     = 0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // Constant ones: full positive scale, clipped, integrators wrap
    pat = 4'b0001; plen = 1; pidx = 0;
    expect_strobes(24'h7FFFE0, 3);
    budget = 0;
    while (edge_no != 2561 && budget < 4000) begin
      step();
      budget++;
    end
    checks++;
    assert (sb.size() == 0 && edge_no == 2561) else begin
      fails++;
      $error("FAIL const1_reach observed pending=%0d edge=%0d expected 0 at 2561", sb.size(), edge_no);
    end
    sb.delete();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pidx  = 0;
    expect_strobes(24'h7FFFE0, 2);
    drain("after_mid_reset");

    // Constant zeros: full negative scale, no clipping
    do_reset("reset_const0");
    pat = 4'b0000; plen = 1; pidx = 0;
    expect_strobes(24'h800000, 3);
    drain("const0");

    // Alternating 1,0: zero mean
    do_reset("reset_alt");
    pat = 4'b0101; plen = 2; pidx = 0;
    expect_strobes(24'h000000, 3);
    drain("alt10");

    // 1,1,1,0: mean +0.5
    do_reset("reset_1110");
    pat = 4'b0111; plen = 4; pidx = 0;
    expect_strobes(24'h400000, 3);
    drain("pat1110");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
